// File: rtl/stage2_gather.sv
// stage2_gather: gathers six serial channel partial sums into parallel lanes and drives the 3-stage adder tree; STAGE2_GATHER_ORDER_CHECK_EN enables in_ch order checking
module stage2_gather #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    input  logic [2:0]                   in_ch,
    output logic signed [DATA_WIDTH-1:0] lane_a,
    output logic signed [DATA_WIDTH-1:0] lane_b,
    output logic signed [DATA_WIDTH-1:0] lane_c,
    output logic signed [DATA_WIDTH-1:0] lane_d,
    output logic signed [DATA_WIDTH-1:0] lane_e,
    output logic signed [DATA_WIDTH-1:0] lane_f,
    output logic                         add_en,
    output logic                         sum_valid,
    output logic                         ch_err
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN1, DRAIN2} state_t;
    state_t state, state_nxt;
    logic [2:0] ch_cnt, cnt_nxt, wr_idx;
    logic signed [DATA_WIDTH-1:0] fill [5];
    logic [2:0] sv_sr;
    logic accept, ch_ok, wr_en, set_done;
    assign accept = in_valid && in_ready;
`ifdef STAGE2_GATHER_ORDER_CHECK_EN
    // a mismatched word restarts the set; channel 0 seeds lane a of the new set
    assign ch_ok   = in_ch == ch_cnt;
    assign wr_en   = accept && (ch_ok ? ch_cnt != 3'd5 : in_ch == 3'd0);
    assign wr_idx  = ch_ok ? ch_cnt : 3'd0;
    assign cnt_nxt = !ch_ok ? {2'b00, in_ch == 3'd0} : ch_cnt == 3'd5 ? 3'd0 : ch_cnt + 3'd1;
    // sticky order error until reset
    always_ff @(posedge clk) begin
        if (rst) ch_err <= 1'b0;
        else if (accept && !ch_ok) ch_err <= 1'b1;
    end
`else
    logic unused_in_ch;
    assign unused_in_ch = ^in_ch;
    assign ch_ok   = 1'b1;
    assign wr_en   = accept && ch_cnt != 3'd5;
    assign wr_idx  = ch_cnt;
    assign cnt_nxt = ch_cnt == 3'd5 ? 3'd0 : ch_cnt + 3'd1;
    assign ch_err  = 1'b0;
`endif
    // word 5 completes the set and goes straight to lane f, so it needs no fill slot
    assign set_done = accept && ch_ok && ch_cnt == 3'd5;
    // a completing set always wins and re-enters ISSUE; otherwise drain toward IDLE
    always_comb begin
        state_nxt = set_done ? ISSUE : state == ISSUE ? DRAIN1 : state == DRAIN1 ? DRAIN2 : IDLE;
    end
    // fill bank and channel counter
    always_ff @(posedge clk) begin
        if (rst) begin
            ch_cnt <= 3'd0;
            for (int i = 0; i < 5; i++) fill[i] <= '0;
        end else begin
            if (accept) ch_cnt <= cnt_nxt;
            if (wr_en) fill[wr_idx] <= in_data;
        end
    end
    // issue registers: lanes carry the set only during ISSUE so the adder pipeline sees zeros otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            in_ready <= 1'b0;
            add_en   <= 1'b0;
            sv_sr    <= 3'b000;
            lane_a   <= '0;
            lane_b   <= '0;
            lane_c   <= '0;
            lane_d   <= '0;
            lane_e   <= '0;
            lane_f   <= '0;
        end else begin
            state    <= state_nxt;
            in_ready <= 1'b1;
            add_en   <= state_nxt != IDLE;
            sv_sr    <= {sv_sr[1:0], state == ISSUE};
            lane_a   <= set_done ? fill[0] : '0;
            lane_b   <= set_done ? fill[1] : '0;
            lane_c   <= set_done ? fill[2] : '0;
            lane_d   <= set_done ? fill[3] : '0;
            lane_e   <= set_done ? fill[4] : '0;
            lane_f   <= set_done ? in_data : '0;
        end
    end
    assign sum_valid = sv_sr[2];
endmodule

// File: doc/stage2_gather.md
# stage2_gather

Front-end for the second-stage six-channel adder tree. It accepts the six per-channel partial sums of one output pixel as a serial stream from the shared convolution engine, collects them into six parallel lanes, and issues each complete set to the adder. It drives the adder's enable for exactly as long as the set needs to propagate through the adder's 3-register pipeline, and produces a `sum_valid` strobe aligned with the adder's `dataout`.

## Interface
- `DATA_WIDTH`, 16, width of each signed partial sum and of each lane.
- `clk` in 1, single clock; all logic is rising-edge.
- `rst` in 1, synchronous, active-high reset.
- `in_valid` in 1, input word valid.
- `in_ready` out 1, input word accepted when `in_valid && in_ready`.
- `in_data` in DATA_WIDTH, signed partial sum for one channel.
- `in_ch` in 3, channel index of `in_data`, values 0..5; used only under `STAGE2_GATHER_ORDER_CHECK_EN`.
- `lane_a` .. `lane_f` out DATA_WIDTH each, signed, channels 0..5, connected to adder inputs a..f.
- `add_en` out 1, adder enable.
- `sum_valid` out 1, adder `dataout` holds a valid sum in this cycle.
- `ch_err` out 1, sticky channel-order error flag.

## Operation
- Channel counter `ch_cnt` (0..5) selects the fill register for each accepted word. The word is written into fill lane `ch_cnt`, then the counter increments. After lane 5 is written, the counter wraps to 0 and the set is marked complete.
- `in_ready` is a registered signal. It is 0 during reset and 1 in every cycle after reset.
  - Sets are complete at most once every 6 cycles and issue takes 1 cycle, so the block never applies backpressure.
  - The fill bank and the issue registers are separate. Word 0 of the next set may be accepted in the same cycle the previous set issues.
- Issue FSM states:
  - IDLE: `add_en`=0.
  - ISSUE: lanes hold the set, `add_en`=1.
  - DRAIN1: lanes=0, `add_en`=1.
  - DRAIN2: lanes=0, `add_en`=1.
- FSM transitions:
  - Set completes → ISSUE, from any state.
  - ISSUE → DRAIN1 → DRAIN2 → IDLE, unless a set completes, which takes priority and re-enters ISSUE.
- Lanes are 0 in every cycle outside ISSUE, so the zeroed adder pipeline never produces a spurious sum.
- `sum_valid` is the ISSUE flag delayed through a 3-stage shift register.
- Arithmetic: lanes pass data through unmodified. Widening and truncation are the adder's responsibility.
- Reset, including mid-set or mid-drain, clears:
  - `ch_cnt`, the fill bank, the FSM (to IDLE) and the `sum_valid` shift register;
  - all lanes to 0, `add_en`=0, `sum_valid`=0, `ch_err`=0.
  - A partially collected set is discarded.
  - With `add_en` low, the adder zeroes its own pipeline, so no stale sum is ever flagged.

## Timing
- All outputs are registered. Reset values: lanes 0, `add_en` 0, `sum_valid` 0, `in_ready` 0, `ch_err` 0.
- Word 5 accepted at the edge ending cycle t:
  - cycle t+1: ISSUE (`add_en`=1, lanes valid);
  - cycles t+2, t+3: drain;
  - cycle t+4: `sum_valid`=1 with the adder sum on `dataout`, `add_en`=0 if no new set.
- Latency from last word accept to `sum_valid` is 4 cycles.
- Continuous `in_valid` gives one `sum_valid` every 6 cycles.
- `in_valid` gaps stall filling only. Drain proceeds regardless.

## Configuration
- `STAGE2_GATHER_ORDER_CHECK_EN` defined:
  - every accepted word is compared with `in_ch` against `ch_cnt`;
  - on mismatch the word is dropped, `ch_err` sets (sticky until `rst`) and the partial set is discarded;
  - if the mismatched word has `in_ch`==0, it is stored as lane a and `ch_cnt` becomes 1; otherwise `ch_cnt` becomes 0.
- `STAGE2_GATHER_ORDER_CHECK_EN` undefined:
  - `in_ch` is ignored;
  - `ch_err` is tied to 0;
  - placement is by counter only.

## Test plan
- Reset, then six words 1,2,3,4,5,6 on consecutive cycles: one ISSUE cycle with lanes a..f=1..6, `add_en` high for 3 cycles, `sum_valid`=1 in the 4th cycle after word 6 with adder `dataout`=21. `sum_valid` is 0 everywhere else.
- Continuous stream of 12 words: -1 ×6 then 100,-50,0,0,0,7. Sums -6 then 57, with `sum_valid` pulses exactly 6 cycles apart and lanes 0 between issues.
- Words with random `in_valid` gaps (set 10,20,30,40,50,60): the sum is 210 regardless of gaps. `sum_valid` comes 4 cycles after the last word, and `add_en` is never high while the set is incomplete.
- `rst` asserted after 3 words of a set and after ISSUE during DRAIN1: all outputs 0 the next cycle and no `sum_valid` follows. A subsequent full set 1..6 yields 21.
- Overflow pass-through, DATA_WIDTH=16, lanes 32767 ×6: lanes present 32767 unmodified and `sum_valid` asserts. Adder wraps per its own width rules.
- Macro defined, `in_ch` sequence 0,1,3,0,1,2,3,4,5 with data 1..9:
  - `ch_err`=1 after the third word;
  - the set issued is 4,5,6,7,8,9 (sum 39);
  - `ch_err` stays 1 until `rst`.
  - Macro undefined, same stimulus: the first six words issue (sum 21) and `ch_err` stays 0.
